// File: rtl/ip_ram_pkg.sv
// rtl/ip_ram_pkg.sv - shared sizes and helpers for the self-exercising RAM block
package ip_ram_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int WR_LAST = DEPTH - 1;
  localparam int CNT_W   = ADDR_W + 1;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Test pattern: every address holds its own index.
  function automatic data_t addr_to_data(input addr_t a);
    return data_t'(a);
  endfunction

endpackage

// File: rtl/ip_ram_sp_ram.sv
// rtl/ip_ram_sp_ram.sv - generic single-port synchronous read-first RAM
module sp_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset so they survive a system reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ip_ram_top.sv
// rtl/ip_ram_top.sv - writes index pattern into a 32x8 RAM, reads it back and flags mismatches
module ip_ram_top
  import ip_ram_pkg::*;
(
  input logic sys_clk,
  input logic sys_rst_n
);

  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam cnt_t CNT_WRLAST = cnt_t'(WR_LAST);

  cnt_t  rw_cnt;
  logic  ram_en;
  logic  ram_wea;
  addr_t ram_addr;
  data_t ram_wr_data;
  data_t ram_rd_data;
  logic  rd_vld;
  data_t rd_exp;
  logic  rd_err;
  logic  w_rd_stb;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_en <= 1'b0;
    end else begin
      ram_en <= 1'b1;
    end
  end

  // Counter starts moving with ram_en so the first enabled cycle sees address 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rw_cnt <= '0;
    end else if (ram_en) begin
      rw_cnt <= rw_cnt + CNT_ONE;
    end
  end

  always_comb begin
    ram_wea     = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    if (ram_en) begin
      ram_addr = rw_cnt[ADDR_W-1:0];
      ram_wea  = (rw_cnt <= CNT_WRLAST);
      if (ram_wea) begin
        ram_wr_data = addr_to_data(rw_cnt[ADDR_W-1:0]);
      end
    end
  end

  assign w_rd_stb = ram_en & ~ram_wea;

  sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (sys_clk),
    .en   (ram_en),
    .we   (ram_wea),
    .addr (ram_addr),
    .din  (ram_wr_data),
    .dout (ram_rd_data)
  );

  // Expected data trails the address by one cycle to line up with the RAM output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_vld <= 1'b0;
      rd_exp <= '0;
      rd_err <= 1'b0;
    end else begin
      rd_vld <= w_rd_stb;
      rd_exp <= addr_to_data(ram_addr);
      rd_err <= rd_err | (rd_vld & (ram_rd_data != rd_exp));
    end
  end

endmodule

// File: tb/tb_ip_ram_top.sv
// tb/tb_ip_ram_top.sv - randomized self-checking bench for ip_ram_top
module tb_ip_ram_top;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #10 sys_clk = ~sys_clk;

  ip_ram_top dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] mm [32];
  int         n;
  bit         in_reset;
  bit         exp_rd_vld;
  logic [7:0] exp_rd;
  int         prev_addr;
  bit         m_err;
  int         cur_cnt;
  int         cur_addr;
  bit         cur_en;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle();
    check("rst_rw_cnt",  32'(dut.rw_cnt),      0);
    check("rst_ram_en",  32'(dut.ram_en),      0);
    check("rst_wea",     32'(dut.ram_wea),     0);
    check("rst_addr",    32'(dut.ram_addr),    0);
    check("rst_wr_data", 32'(dut.ram_wr_data), 0);
    check("rst_rd_vld",  32'(dut.rd_vld),      0);
    check("rst_rd_err",  32'(dut.rd_err),      0);
  endtask

  // One sample per cycle, taken on the falling edge; then advance the model across the next rising edge.
  task automatic step_check();
    int cnt;
    bit en, wea;
    int addr, wdat;
    if (in_reset) begin
      check_idle();
      return;
    end
    if (exp_rd_vld) check("rd_data", 32'(dut.ram_rd_data), 32'(exp_rd));
    check("rd_err", 32'(dut.rd_err), 32'(m_err));
    en   = (n != 0);
    cnt  = en ? (n - 1) % 64 : 0;
    wea  = en && (cnt < 32);
    addr = en ? cnt % 32 : 0;
    wdat = wea ? addr : 0;
    check("ram_en",  32'(dut.ram_en),      32'(en));
    check("rw_cnt",  32'(dut.rw_cnt),      32'(cnt));
    check("wea",     32'(dut.ram_wea),     32'(wea));
    check("addr",    32'(dut.ram_addr),    32'(addr));
    check("wr_data", 32'(dut.ram_wr_data), 32'(wdat));
    if (exp_rd_vld && (exp_rd != 8'(prev_addr))) m_err = 1'b1;
    exp_rd_vld = en && !wea;
    if (en) exp_rd = mm[addr];
    prev_addr = addr;
    if (wea) mm[addr] = 8'(addr);
    cur_cnt  = cnt;
    cur_addr = addr;
    cur_en   = en;
    n++;
  endtask

  task automatic run_cycles(input int k);
    repeat (k) begin
      @(negedge sys_clk);
      step_check();
    end
  endtask

  task automatic run_until_cnt(input int target);
    int guard = 0;
    do begin
      @(negedge sys_clk);
      step_check();
      guard++;
    end while (!(cur_en && cur_cnt == target) && guard < 200);
    if (guard >= 200) check("cnt_timeout", 32'(guard), 0);
  endtask

  task automatic release_reset();
    sys_rst_n  = 1'b1;
    in_reset   = 1'b0;
    n          = 0;
    exp_rd_vld = 1'b0;
    m_err      = 1'b0;
    prev_addr  = 0;
    step_check();
  endtask

  task automatic mid_reset(input int hold);
    sys_rst_n = 1'b0;
    in_reset  = 1'b1;
    #1;
    check_idle();
    repeat (hold) begin
      @(negedge sys_clk);
      step_check();
    end
    release_reset();
  endtask

  task automatic inject(input int a, input logic [7:0] v);
    dut.u_ram.mem[a] = v;
    mm[a] = v;
  endtask

  initial begin
    int a;
    logic [7:0] v;
    in_reset   = 1'b1;
    exp_rd_vld = 1'b0;
    m_err      = 1'b0;
    n          = 0;
    prev_addr  = 0;
    cur_en     = 1'b0;
    cur_cnt    = 0;
    cur_addr   = 0;
    for (int i = 0; i < 32; i++) mm[i] = 8'hxx;

    run_cycles(20);
    @(negedge sys_clk);
    release_reset();

    run_cycles(33);
    for (int i = 0; i < 32; i++) check("mem_after_wr", 32'(dut.u_ram.mem[i]), 32'(i));

    run_cycles(3 * 64 - 33);

    // corrupt address 5 early in the read phase, then reset partway through reading
    run_until_cnt(33);
    inject(5, 8'hAA);
    run_until_cnt(40);
    check("err_injected", 32'(dut.rd_err), 1);
    mid_reset(3);
    check("mem10_kept", 32'(dut.u_ram.mem[10]), 10);
    run_cycles(70);
    check("err_after_rewrite", 32'(dut.rd_err), 0);

    for (int it = 0; it < 6; it++) begin
      run_cycles($urandom_range(10, 150));
      if (cur_en && cur_cnt >= 32 && $urandom_range(0, 1) == 1) begin
        a = (cur_addr + 1 + $urandom_range(0, 30)) % 32;
        v = 8'($urandom_range(0, 255));
        inject(a, v);
      end
      run_cycles($urandom_range(1, 40));
      if ($urandom_range(0, 2) != 0) mid_reset($urandom_range(1, 5));
    end
    run_cycles(130);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
